// File: rtl/sm4_pkg.sv
// Shared SM4 constants, FSM state type and word helpers for the iterative engine.
package sm4_pkg;

    localparam int ROUNDS = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_KEYEXP,
        ST_CRYPT,
        ST_OUTPUT
    } sm4_state_e;

    localparam logic [7:0] SBOX [0:255] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    localparam logic [31:0] CK [0:31] = '{
        32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
        32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
        32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
        32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
        32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
        32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
        32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
        32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
    };

    localparam logic [31:0] FK [0:3] = '{
        32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc
    };

    // n must lie in 1..31
    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/sm4_round.sv
// One SM4 round word: new = X0 ^ L(tau(X1^X2^X3^rc)), with L' for key schedule or L for cipher.
module sm4_round
    import sm4_pkg::*;
(
    input  logic [31:0] i_x0,
    input  logic [31:0] i_x1,
    input  logic [31:0] i_x2,
    input  logic [31:0] i_x3,
    input  logic [31:0] i_rc,
    input  logic        i_sel_key,
    output logic [31:0] o_new
);

    logic [31:0] w_t;
    logic [31:0] w_b;
    logic [31:0] w_l;

    assign w_t = i_x1 ^ i_x2 ^ i_x3 ^ i_rc;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            assign w_b[8*gi +: 8] = SBOX[w_t[8*gi +: 8]];
        end
    endgenerate

    always_comb begin
        w_l = '0;
        if (i_sel_key) begin
            w_l = w_b ^ rotl32(w_b, 13) ^ rotl32(w_b, 23);
        end else begin
            w_l = w_b ^ rotl32(w_b, 2) ^ rotl32(w_b, 10) ^ rotl32(w_b, 18) ^ rotl32(w_b, 24);
        end
    end

    assign o_new = i_x0 ^ w_l;

endmodule

// File: rtl/sm4_iter_engine.sv
// Iterative SM4: expands the master key into 32 round-key registers, then runs
// one round per cycle on each block, sharing a single round datapath.
module sm4_iter_engine #(
    parameter int ROUNDS = sm4_pkg::ROUNDS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [7:0] key [0:15],
    output logic       key_loaded,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_mode,
    input  logic [7:0] in_data [0:15],
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data [0:15]
);
    import sm4_pkg::*;

    localparam int CNT_W = $clog2(ROUNDS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

    sm4_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_x [0:3];
    logic [31:0]      r_rk [0:ROUNDS-1];
    logic             r_mode;
    logic             r_key_loaded;
    logic             r_out_valid;
    logic [127:0]     r_out_data;

    logic [31:0]      w_mk [0:3];
    logic [31:0]      w_in [0:3];
    logic [CNT_W-1:0] w_rk_idx;
    logic [31:0]      w_rc;
    logic             w_sel_key;
    logic [31:0]      w_new;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_words
            assign w_mk[gi] = {key[4*gi], key[4*gi+1], key[4*gi+2], key[4*gi+3]};
            assign w_in[gi] = {in_data[4*gi], in_data[4*gi+1], in_data[4*gi+2], in_data[4*gi+3]};
        end
        for (genvar gi = 0; gi < 16; gi++) begin : g_out
            assign out_data[gi] = r_out_data[127-8*gi -: 8];
        end
    endgenerate

    // Decryption walks the round keys in reverse order
    assign w_rk_idx  = r_mode ? r_cnt : (LAST - r_cnt);
    assign w_sel_key = (r_state == ST_KEYEXP);
    assign w_rc      = w_sel_key ? CK[r_cnt] : r_rk[w_rk_idx];

    sm4_round u_round (
        .i_x0      (r_x[0]),
        .i_x1      (r_x[1]),
        .i_x2      (r_x[2]),
        .i_x3      (r_x[3]),
        .i_rc      (w_rc),
        .i_sel_key (w_sel_key),
        .o_new     (w_new)
    );

    assign key_ready  = (r_state == ST_IDLE);
    assign in_ready   = (r_state == ST_IDLE) && r_key_loaded && !key_valid;
    assign key_loaded = r_key_loaded;
    assign out_valid  = r_out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_x[0]       <= '0;
            r_x[1]       <= '0;
            r_x[2]       <= '0;
            r_x[3]       <= '0;
            r_mode       <= 1'b0;
            r_key_loaded <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (key_valid) begin
                        r_x[0]       <= w_mk[0] ^ FK[0];
                        r_x[1]       <= w_mk[1] ^ FK[1];
                        r_x[2]       <= w_mk[2] ^ FK[2];
                        r_x[3]       <= w_mk[3] ^ FK[3];
                        r_key_loaded <= 1'b0;
                        r_cnt        <= '0;
                        r_state      <= ST_KEYEXP;
                    end else if (in_valid && r_key_loaded) begin
                        r_x[0]  <= w_in[0];
                        r_x[1]  <= w_in[1];
                        r_x[2]  <= w_in[2];
                        r_x[3]  <= w_in[3];
                        r_mode  <= in_mode;
                        r_cnt   <= '0;
                        r_state <= ST_CRYPT;
                    end
                end
                ST_KEYEXP, ST_CRYPT: begin
                    r_x[0] <= r_x[1];
                    r_x[1] <= r_x[2];
                    r_x[2] <= r_x[3];
                    r_x[3] <= w_new;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        if (r_state == ST_KEYEXP) begin
                            r_key_loaded <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_out_data  <= {w_new, r_x[3], r_x[2], r_x[1]};
                            r_out_valid <= 1'b1;
                            r_state     <= ST_OUTPUT;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Round-key file needs no reset: key_loaded gates its use
    always_ff @(posedge clk) begin
        if (r_state == ST_KEYEXP) begin
            r_rk[r_cnt] <= w_new;
        end
    end

endmodule
